vx_alu_subunit_router: RTL and testbench

VX_ALU_SUBUNIT_ROUTER -- requirements
Module: VX_alu_subunit_router

---
 rtl/vx_alu_subunit_router_pkg.sv | 24 ++
 rtl/vx_alu_subunit_router_rr_arbiter.sv | 65 ++++++
 rtl/vx_alu_subunit_router.sv | 168 ++++++++++++++++
 tb/tb_vx_alu_subunit_router.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_alu_subunit_router_pkg.sv
`default_nettype none
// ============================================================================
// Module : vx_alu_subunit_router_pkg
// Brief  : Shared constants for the ALU sub-unit router: sub-unit indices,
//          outstanding-counter width and a select-width helper.
// Rev    : 1.0 - initial release
// ============================================================================
package vx_alu_subunit_router_pkg;

  // Sub-unit index assignment used by the issue decoder
  localparam int SUBUNIT_INT = 0;
  localparam int SUBUNIT_MDV = 1;
  localparam int SUBUNIT_RED = 2;

  // Width of each per-sub-unit in-flight counter (holds up to 15)
  localparam int CNT_W = 4;

  // Width of an index over n entries, never less than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_alu_subunit_router_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vx_alu_subunit_router_rr_arbiter
// Brief  : Round-robin arbiter. Highest priority goes to the entry after the
//          last accepted grant; the pointer moves only when unlock is high.
// Rev    : 1.0 - initial release
// ============================================================================
module vx_alu_subunit_router_rr_arbiter #(
  parameter int NUM_REQS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQS-1:0]         requests,
  input  logic                        unlock,
  output logic [NUM_REQS-1:0]         grant_onehot,
  output logic [$clog2(NUM_REQS)-1:0] grant_index,
  output logic                        grant_valid
);

  localparam int C_IDX_W = $clog2(NUM_REQS);
  localparam logic [C_IDX_W:0] C_NUM = (C_IDX_W + 1)'(NUM_REQS);

  logic [C_IDX_W-1:0] last_grant_q;
  logic [C_IDX_W-1:0] last_grant_d;
  logic [C_IDX_W:0]   w_sum;

  // Scan from lowest to highest priority so the highest-priority hit wins last
  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    w_sum        = '0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      w_sum = {1'b0, last_grant_q} + (C_IDX_W + 1)'(k);
      if (w_sum >= C_NUM) begin
        w_sum = w_sum - C_NUM;
      end
      if (requests[w_sum[C_IDX_W-1:0]]) begin
        grant_valid  = 1'b1;
        grant_index  = w_sum[C_IDX_W-1:0];
        grant_onehot = '0;
        grant_onehot[w_sum[C_IDX_W-1:0]] = 1'b1;
      end
    end
  end

  // Advance the pointer only when the grant is actually taken
  always_comb begin
    last_grant_d = last_grant_q;
    if (unlock && grant_valid) begin
      last_grant_d = grant_index;
    end
  end

  // Pointer resets to the final entry so entry 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= C_IDX_W'(NUM_REQS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_alu_subunit_router.sv
`default_nettype none
// ============================================================================
// Module : vx_alu_subunit_router
// Brief  : Routes ALU requests to one of NUM_SUBUNITS execution sub-units,
//          tracks in-flight counts per sub-unit, and merges the responses
//          through a round-robin arbiter into a one-entry output register.
// Rev    : 1.0 - initial release
// ============================================================================
module vx_alu_subunit_router
  import vx_alu_subunit_router_pkg::*;
#(
  parameter int                    NUM_SUBUNITS    = 3,
  parameter int                    REQ_DATAW       = 64,
  parameter int                    RSP_DATAW       = 64,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [NUM_SUBUNITS-1:0] SUBUNIT_EN    = '1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic [$clog2(NUM_SUBUNITS)-1:0]   req_sel,
  input  logic [REQ_DATAW-1:0]              req_data,
  output logic                              req_ready,
  output logic [NUM_SUBUNITS-1:0]           sub_req_valid,
  output logic [REQ_DATAW-1:0]              sub_req_data,
  input  logic [NUM_SUBUNITS-1:0]           sub_req_ready,
  input  logic [NUM_SUBUNITS-1:0]           sub_rsp_valid,
  input  logic [NUM_SUBUNITS*RSP_DATAW-1:0] sub_rsp_data,
  output logic [NUM_SUBUNITS-1:0]           sub_rsp_ready,
  output logic                              rsp_valid,
  output logic [RSP_DATAW-1:0]              rsp_data,
  output logic [$clog2(NUM_SUBUNITS)-1:0]   rsp_sel,
  input  logic                              rsp_ready,
  output logic                              err_illegal,
  output logic                              idle
);

  localparam int              C_SEL_W = $clog2(NUM_SUBUNITS);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]     cnt_q [NUM_SUBUNITS];
  logic [CNT_W-1:0]     cnt_d [NUM_SUBUNITS];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [RSP_DATAW-1:0] rsp_data_q,  rsp_data_d;
  logic [C_SEL_W-1:0]   rsp_sel_q,   rsp_sel_d;
  logic                 err_q,       err_d;

  logic                    w_sel_en;
  logic                    w_sel_room;
  logic                    w_sel_rdy;
  logic                    w_illegal_req;
  logic                    w_arb_en;
  logic [NUM_SUBUNITS-1:0] w_grant_oh;
  logic [C_SEL_W-1:0]      w_grant_idx;
  logic                    w_grant_valid;

  assign sub_req_data = req_data;

  // Request path: look up the target, steer valid, and derive ready
  always_comb begin
    w_sel_en      = 1'b0;
    w_sel_room    = 1'b0;
    w_sel_rdy     = 1'b0;
    sub_req_valid = '0;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      if (req_sel == C_SEL_W'(i)) begin
        w_sel_en   = SUBUNIT_EN[i];
        w_sel_room = (cnt_q[i] < C_MAX);
        w_sel_rdy  = sub_req_ready[i];
      end
      sub_req_valid[i] = req_valid && (req_sel == C_SEL_W'(i)) &&
                         SUBUNIT_EN[i] && (cnt_q[i] < C_MAX);
    end
    // Unmapped or absent targets are swallowed so the issue stage never hangs
    req_ready     = w_sel_en ? (w_sel_rdy && w_sel_room) : 1'b1;
    w_illegal_req = req_valid && !w_sel_en;
  end

  // Arbitrate whenever the output slot is free or being drained
  assign w_arb_en      = !rsp_valid_q || rsp_ready;
  assign sub_rsp_ready = w_arb_en ? w_grant_oh : '0;

  vx_alu_subunit_router_rr_arbiter #(
    .NUM_REQS (NUM_SUBUNITS)
  ) u_rsp_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (sub_rsp_valid),
    .unlock       (w_arb_en),
    .grant_onehot (w_grant_oh),
    .grant_index  (w_grant_idx),
    .grant_valid  (w_grant_valid)
  );

  // In-flight bookkeeping and sticky error detection
  always_comb begin
    err_d = err_q || w_illegal_req;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((sub_req_valid[i] && sub_req_ready[i]) &&
          !(sub_rsp_valid[i] && sub_rsp_ready[i])) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!(sub_req_valid[i] && sub_req_ready[i]) &&
                   (sub_rsp_valid[i] && sub_rsp_ready[i]) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      // A response with nothing outstanding is taken but flagged
      if (sub_rsp_valid[i] && sub_rsp_ready[i] && (cnt_q[i] == '0)) begin
        err_d = 1'b1;
      end
    end
  end

  // Output slot: load the granted response, hold it while stalled
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    if (w_arb_en) begin
      rsp_valid_d = w_grant_valid;
      if (w_grant_valid) begin
        rsp_sel_d = w_grant_idx;
        for (int i = 0; i < NUM_SUBUNITS; i++) begin
          if (w_grant_oh[i]) begin
            rsp_data_d = sub_rsp_data[i*RSP_DATAW +: RSP_DATAW];
          end
        end
      end
    end
  end

  // Idle means nothing outstanding anywhere and the output slot empty
  always_comb begin
    idle = !rsp_valid_q;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      if (cnt_q[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SUBUNITS; i++) begin
        cnt_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_sel     = rsp_sel_q;
  assign err_illegal = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_alu_subunit_router.sv
`default_nettype none
// ============================================================================
// Module : tb_vx_alu_subunit_router
// Brief  : Self-checking bench for vx_alu_subunit_router: a vector table for
//          routing, a response scoreboard with a reference model, and
//          directed sequences for stalls, saturation and reset.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vx_alu_subunit_router;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;

  logic            req_valid;
  logic [SW-1:0]   req_sel;
  logic [DW-1:0]   req_data;
  logic            req_ready;
  logic [N-1:0]    sub_req_valid;
  logic [DW-1:0]   sub_req_data;
  logic [N-1:0]    sub_req_ready;
  logic [N-1:0]    sub_rsp_valid;
  logic [N*DW-1:0] sub_rsp_data;
  logic [N-1:0]    sub_rsp_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [SW-1:0]   rsp_sel;
  logic            rsp_ready;
  logic            err_illegal;
  logic            idle;

  logic            d2_req_valid;
  logic [SW-1:0]   d2_req_sel;
  logic            d2_req_ready;
  logic [N-1:0]    d2_sub_req_valid;
  logic [DW-1:0]   d2_sub_req_data;
  logic [N-1:0]    d2_sub_rsp_ready;
  logic            d2_rsp_valid;
  logic [DW-1:0]   d2_rsp_data;
  logic [SW-1:0]   d2_rsp_sel;
  logic            d2_err;
  logic            d2_idle;

  always #5 clk = ~clk;

  vx_alu_subunit_router #(
    .NUM_SUBUNITS(N), .REQ_DATAW(DW), .RSP_DATAW(DW),
    .MAX_OUTSTANDING(4), .SUBUNIT_EN(3'b111)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
    .req_ready(req_ready),
    .sub_req_valid(sub_req_valid), .sub_req_data(sub_req_data),
    .sub_req_ready(sub_req_ready),
    .sub_rsp_valid(sub_rsp_valid), .sub_rsp_data(sub_rsp_data),
    .sub_rsp_ready(sub_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sel(rsp_sel),
    .rsp_ready(rsp_ready),
    .err_illegal(err_illegal), .idle(idle)
  );

  // Second instance with sub-unit 2 absent
  vx_alu_subunit_router #(
    .NUM_SUBUNITS(N), .REQ_DATAW(DW), .RSP_DATAW(DW),
    .MAX_OUTSTANDING(4), .SUBUNIT_EN(3'b011)
  ) dut_en (
    .clk(clk), .reset(reset),
    .req_valid(d2_req_valid), .req_sel(d2_req_sel), .req_data(req_data),
    .req_ready(d2_req_ready),
    .sub_req_valid(d2_sub_req_valid), .sub_req_data(d2_sub_req_data),
    .sub_req_ready(3'b111),
    .sub_rsp_valid(3'b000), .sub_rsp_data(sub_rsp_data),
    .sub_rsp_ready(d2_sub_rsp_ready),
    .rsp_valid(d2_rsp_valid), .rsp_data(d2_rsp_data), .rsp_sel(d2_rsp_sel),
    .rsp_ready(1'b1),
    .err_illegal(d2_err), .idle(d2_idle)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } rsp_t;
  rsp_t sb_q[$];

  typedef struct {
    logic          v;
    logic [SW-1:0] sel;
    logic [N-1:0]  srdy;
    logic [N-1:0]  e_srv;
    logic          e_rr;
  } vec_t;
  vec_t vt[6];

  int m_cnt[N];
  int m_last;
  bit m_err;
  int tag = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_last = N - 1;
    m_err  = 1'b0;
  endtask

  // One clock: drive data, check against the model, advance the model
  task automatic cycle();
    logic [N-1:0] e_srv;
    logic [N-1:0] e_grant;
    logic         e_rr;
    bit           legal, en, found, pop, inc, dec;
    int           g, idx;
    rsp_t         item;
    for (int i = 0; i < N; i++) sub_rsp_data[i*DW +: DW] = {24'hC0DE00, 8'(i), 32'(tag)};
    #2;
    legal = (int'(req_sel) < N);
    e_srv = '0;
    for (int i = 0; i < N; i++)
      if (req_valid && int'(req_sel) == i && m_cnt[i] < 4) e_srv[i] = 1'b1;
    if (legal) e_rr = sub_req_ready[req_sel] && (m_cnt[req_sel] < 4);
    else       e_rr = 1'b1;
    en    = (sb_q.size() == 0) || rsp_ready;
    found = 1'b0;
    g     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (m_last + k) % N;
      if (sub_rsp_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    e_grant = (en && found) ? N'(1 << g) : '0;
    check("sub_req_valid", sub_req_valid, e_srv);
    check("req_ready", req_ready, e_rr);
    check("sub_rsp_ready", sub_rsp_ready, e_grant);
    check("rsp_valid", rsp_valid, sb_q.size() != 0);
    check("err_illegal", err_illegal, m_err);
    check("idle", idle, (m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0 && sb_q.size() == 0));
    if (sb_q.size() != 0) begin
      check("rsp_data", rsp_data, sb_q[0].data);
      check("rsp_sel", rsp_sel, sb_q[0].sel);
    end
    pop       = (sb_q.size() != 0) && rsp_ready;
    item.data = sub_rsp_data[g*DW +: DW];
    item.sel  = SW'(g);
    @(posedge clk);
    #1;
    if (pop) void'(sb_q.pop_front());
    if (en && found) begin
      sb_q.push_back(item);
      m_last = g;
    end
    for (int i = 0; i < N; i++) begin
      inc = e_srv[i] && sub_req_ready[i];
      dec = en && found && (g == i);
      if (dec && m_cnt[i] == 0) m_err = 1'b1;
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
    end
    if (req_valid && !legal) m_err = 1'b1;
    tag++;
    @(negedge clk);
  endtask

  task automatic quiet();
    req_valid     = 1'b0;
    sub_rsp_valid = '0;
    sub_req_ready = '1;
    rsp_ready     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    logic [DW-1:0] held;
    seq = '{0, 1, 2, 0, 1};
    vt[0] = '{1'b1, 2'd0, 3'b111, 3'b001, 1'b1};
    vt[1] = '{1'b1, 2'd1, 3'b111, 3'b010, 1'b1};
    vt[2] = '{1'b1, 2'd2, 3'b011, 3'b100, 1'b0};
    vt[3] = '{1'b0, 2'd2, 3'b100, 3'b000, 1'b1};
    vt[4] = '{1'b1, 2'd3, 3'b111, 3'b000, 1'b1};
    vt[5] = '{1'b1, 2'd1, 3'b101, 3'b010, 1'b0};

    reset = 1'b1;
    quiet();
    req_sel      = '0;
    req_data     = 64'h0123_4567_89AB_CDEF;
    sub_rsp_data = '0;
    d2_req_valid = 1'b0;
    d2_req_sel   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_sel", rsp_sel, 0);
    check("reset_err", err_illegal, 0);
    check("reset_idle", idle, 1);
    check("reset_d2_idle", d2_idle, 1);
    @(negedge clk);

    // Combinational routing table, deasserted before any edge
    for (int i = 0; i < 6; i++) begin
      req_valid     = vt[i].v;
      req_sel       = vt[i].sel;
      sub_req_ready = vt[i].srdy;
      req_data      = {32'hFACE0000, 32'(i)};
      #1;
      check("tbl_sub_req_valid", sub_req_valid, vt[i].e_srv);
      check("tbl_req_ready", req_ready, vt[i].e_rr);
      check("tbl_sub_req_data", sub_req_data, {32'hFACE0000, 32'(i)});
      quiet();
      @(negedge clk);
    end
    check("tbl_no_side_effect_idle", idle, 1);

    // Round-robin over three always-valid sub-units
    req_valid = 1'b1;
    for (int s = 0; s < N; s++) begin
      req_sel = SW'(s);
      cycle();
      cycle();
    end
    req_valid     = 1'b0;
    sub_rsp_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_valid", rsp_valid, 1);
      check("rr_sel", rsp_sel, seq[k]);
    end
    sub_rsp_valid = '0;
    cycle();
    sub_rsp_valid = 3'b100;
    cycle();
    sub_rsp_valid = '0;
    cycle();
    check("rr_drain_idle", idle, 1);

    // Output stall: slot held, no new grants
    req_valid = 1'b1;
    req_sel   = 2'd0;
    cycle();
    req_sel   = 2'd1;
    cycle();
    req_valid     = 1'b0;
    sub_rsp_valid = 3'b001;
    rsp_ready     = 1'b0;
    cycle();
    held          = rsp_data;
    sub_rsp_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_sub_rsp_ready", sub_rsp_ready, 0);
      cycle();
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_data", rsp_data, held);
      check("stall_rsp_sel", rsp_sel, 0);
    end
    rsp_ready = 1'b1;
    cycle();
    sub_rsp_valid = '0;
    cycle();
    check("stall_drain_idle", idle, 1);

    // Simultaneous request and response on sub-unit 0
    req_valid = 1'b1;
    req_sel   = 2'd0;
    cycle();
    cycle();
    sub_rsp_valid = 3'b001;
    cycle();
    req_valid = 1'b0;
    cycle();
    sub_rsp_valid = '0;
    cycle();
    check("same_cycle_not_idle", idle, 0);
    sub_rsp_valid = 3'b001;
    cycle();
    sub_rsp_valid = '0;
    cycle();
    check("same_cycle_drain_idle", idle, 1);
    check("same_cycle_err", err_illegal, 0);

    // Fill sub-unit 1 to its limit, then free one slot
    req_valid = 1'b1;
    req_sel   = 2'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fill_req_ready", req_ready, 1);
      cycle();
    end
    #1;
    check("full_req_ready", req_ready, 0);
    check("full_sub_req_valid", sub_req_valid, 0);
    cycle();
    sub_rsp_valid = 3'b010;
    #1;
    check("full_rsp_cycle_req_ready", req_ready, 0);
    cycle();
    sub_rsp_valid = '0;
    #1;
    check("fifth_req_ready", req_ready, 1);
    cycle();
    req_valid     = 1'b0;
    sub_rsp_valid = 3'b010;
    repeat (4) cycle();
    sub_rsp_valid = '0;
    cycle();
    check("full_drain_idle", idle, 1);

    // Asynchronous reset with counts and a held response
    req_valid = 1'b1;
    req_sel   = 2'd0;
    repeat (3) cycle();
    req_sel   = 2'd1;
    cycle();
    req_valid     = 1'b0;
    sub_rsp_valid = 3'b010;
    rsp_ready     = 1'b0;
    cycle();
    sub_rsp_valid = '0;
    check("pre_reset_rsp_valid", rsp_valid, 1);
    check("pre_reset_idle", idle, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rsp_valid", rsp_valid, 0);
    check("async_rsp_data", rsp_data, 0);
    check("async_rsp_sel", rsp_sel, 0);
    check("async_idle", idle, 1);
    check("async_err", err_illegal, 0);
    model_reset();
    @(negedge clk);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int s = 0; s < N; s++) begin
      req_sel = SW'(s);
      cycle();
    end
    req_valid     = 1'b0;
    sub_rsp_valid = 3'b111;
    #1;
    check("post_reset_first_grant", sub_rsp_ready, 3'b001);
    repeat (3) cycle();
    sub_rsp_valid = '0;
    cycle();
    check("post_reset_idle", idle, 1);
    check("post_reset_err", err_illegal, 0);

    // Out-of-range select is consumed and flagged
    req_valid = 1'b1;
    req_sel   = 2'd3;
    #1;
    check("oor_req_ready", req_ready, 1);
    check("oor_sub_req_valid", sub_req_valid, 0);
    cycle();
    req_valid = 1'b0;
    check("oor_err_set", err_illegal, 1);
    repeat (2) cycle();
    check("oor_err_sticky", err_illegal, 1);

    // Disabled sub-unit on the masked instance
    check("en_err_initial", d2_err, 0);
    d2_req_valid = 1'b1;
    d2_req_sel   = 2'd0;
    #1;
    check("en_sel0_sub_req_valid", d2_sub_req_valid, 3'b001);
    d2_req_sel = 2'd2;
    #1;
    check("en_sel2_req_ready", d2_req_ready, 1);
    check("en_sel2_sub_req_valid", d2_sub_req_valid, 0);
    check("en_sel2_err_same_cycle", d2_err, 0);
    @(posedge clk);
    #1;
    check("en_sel2_err_next", d2_err, 1);
    check("en_sel2_no_rsp", d2_rsp_valid, 0);
    @(negedge clk);
    d2_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("en_err_hold", d2_err, 1);
    check("en_idle", d2_idle, 1);
    check("en_sub_rsp_ready", d2_sub_rsp_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
